fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- PC generation plus IF/ID pipeline register.
- Sits directly upstream of the instruction ROM (drives its byte address) and directly downstream of it (registers the returned word for decode).
- Supports a valid/ready handshake to decode, redirect (branch/jump) with flush, misaligned-target trap, and a saturating fetch counter.

Parameters:
- INS_ADDRESS, 9: byte-address width of instruction memory (word index = address[INS_ADDRESS-1:2]).
- INS_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset; must be word-aligned.
- CNT_W, 16: fetch counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_ra  out  INS_ADDRESS  byte address to instruction ROM; equals pc combinationally.
- imem_rd  in  INS_W  instruction word from ROM, combinational on imem_ra.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  INS_ADDRESS  target byte address.
- out_valid  out  1  IF/ID slot holds a valid instruction.
- out_ready  in  1  decode accepts the slot this cycle.
- out_instr  out  INS_W  registered instruction.
- out_pc  out  INS_ADDRESS  byte address of out_instr.
- out_pc4  out  INS_ADDRESS  out_pc+4, modulo 2^INS_ADDRESS.
- trap  out  1  sticky misaligned-redirect flag.
- fetch_count  out  CNT_W  number of instructions accepted by decode, saturating.

Behaviour:
- Reset (async, reset_n=0) sets:
  - state=BOOT, pc=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, out_pc4=0.
  - trap=0, fetch_count=0.
- States:
  - BOOT: one cycle after reset release. Outputs stay at reset values, pc holds. Goes to RUN. A redirect in BOOT is ignored.
  - RUN: normal fetch.
  - TRAP: halted. out_valid=0, pc holds, trap=1. Exits only on reset.
- advance = !out_valid || out_ready.
- RUN priority, highest first:
  1. redirect_valid with redirect_pc[1:0]!=0: go to TRAP, set trap=1, clear out_valid, pc unchanged.
  2. redirect_valid, aligned: pc<=redirect_pc, out_valid<=0 (flush slot even if not yet accepted). Redirect beats stall.
  3. advance: out_instr<=imem_rd, out_pc<=pc, out_pc4<=pc+4, out_valid<=1, pc<=pc+4.
  4. Otherwise (stall: out_valid && !out_ready): hold all registers; imem_ra stays stable.
- Latency: an instruction appears on out_* one cycle after its pc is driven. Throughput is 1/cycle while out_ready=1. First valid output is on the 2nd edge after reset release (BOOT edge, then fetch edge).
- Wrap-around: pc+4 drops the carry out of INS_ADDRESS bits, so 0x1FC is followed by 0x000 with no error.
- fetch_count increments on every out_valid && out_ready edge, including the one coinciding with a redirect (the accepted slot counts). It saturates at all-ones.
- pc[1:0] is always 0. An assertion in the bench checks this.
- Reset mid-stall or mid-redirect: asynchronous clear; no partial state survives.

Decomposition:
- Shared package fetch_pkg:
  - state enum fetch_state_t {BOOT, RUN, TRAP}.
  - PC increment constant (4).
  - Alignment mask constant.
- One natural sub-module: pc_reg. It holds the PC register with next-pc mux (hold / +4 / redirect) and reset value.
- IF/ID slot, FSM and counter stay in fetch_stage.

Test Plan:
- Reset, ROM word0=0x00007033, word1=0x00100093, out_ready=1 → cycle 2: out_valid=1, out_instr=0x00007033, out_pc=0x000, out_pc4=0x004; cycle 3: out_instr=0x00100093, out_pc=0x004.
- Hold out_ready=0 for 3 cycles with slot at pc 0x008 (0x00200113) → out_* and imem_ra=0x00C stable; fetch_count unchanged. On release, next slot is pc 0x00C.
- redirect_valid=1, redirect_pc=0x020 while stalled → next edge out_valid=0. Following edge out_pc=0x020 with instruction word 8 (0x00208433).
- Redirect to 0x1FC, out_ready=1 → slots at pc 0x1FC, then 0x000 (wrap), out_pc4 of first = 0x000.
- redirect_pc=0x022 → trap=1, out_valid=0 indefinitely despite out_ready=1. Asserting reset_n=0 clears trap and restarts from RESET_PC.
- CNT_W=4, 20 accepted slots → fetch_count reads 15 and stays; async reset mid-run → count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch controller states (BOOT, RUN, TRAP)
//   PC_INC        : byte distance between sequential instructions
//   ALIGN_MASK    : low PC bits that must be zero for a word-aligned target
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC     = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // True when a byte address is not on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage : fetch_pkg

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection.
//   clk, reset_n  : clock, async active-low reset (loads RESET_PC)
//   load_i        : take target_i as the next PC (redirect)
//   incr_i        : step to the next sequential instruction
//   target_i      : redirect byte address
//   pc_o          : current PC (registered)
//   pc_plus4_c    : pc_o + PC_INC, wrapping modulo 2^INS_ADDRESS (combinational)
module pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic                   incr_i,
  input  logic [INS_ADDRESS-1:0] target_i,
  output logic [INS_ADDRESS-1:0] pc_o,
  output logic [INS_ADDRESS-1:0] pc_plus4_c
);

  logic [INS_ADDRESS-1:0] pc_q;
  logic [INS_ADDRESS-1:0] pc_d;

  // Carry out of the top bit is dropped so the PC wraps to zero.
  assign pc_plus4_c = pc_q + INS_ADDRESS'(PC_INC);

  // Next-PC mux: redirect wins over sequential step; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (incr_i) begin
      pc_d = pc_plus4_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= INS_ADDRESS'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_reg

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation plus the IF/ID pipeline slot.
//   clk, reset_n    : clock, async active-low reset
//   imem_ra         : byte address to instruction ROM (the PC register)
//   imem_rd         : instruction word returned by the ROM for imem_ra
//   redirect_valid  : branch/jump taken this cycle
//   redirect_pc     : redirect target byte address
//   out_valid       : IF/ID slot holds a valid instruction
//   out_ready       : decode accepts the slot this cycle
//   out_instr       : registered instruction
//   out_pc, out_pc4 : byte address of out_instr and that address + 4
//   trap            : sticky misaligned-redirect flag (cleared only by reset)
//   fetch_count     : saturating count of slots accepted by decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INS_W-1:0]       out_instr,
  output logic [INS_ADDRESS-1:0] out_pc,
  output logic [INS_ADDRESS-1:0] out_pc4,
  output logic                   trap,
  output logic [CNT_W-1:0]       fetch_count
);

  fetch_state_t state_q, state_d;

  logic                   valid_q, valid_d;
  logic [INS_W-1:0]       instr_q, instr_d;
  logic [INS_ADDRESS-1:0] opc_q, opc_d;
  logic [INS_ADDRESS-1:0] opc4_q, opc4_d;
  logic                   trap_q, trap_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   pc_load;
  logic                   pc_incr;
  logic [INS_ADDRESS-1:0] pc;
  logic [INS_ADDRESS-1:0] pc_plus4;
  logic                   advance;
  logic                   accept;

  pc_reg #(
    .INS_ADDRESS (INS_ADDRESS),
    .RESET_PC    (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (pc_load),
    .incr_i     (pc_incr),
    .target_i   (redirect_pc),
    .pc_o       (pc),
    .pc_plus4_c (pc_plus4)
  );

  // The slot can take a new word when it is empty or being drained.
  assign advance = !valid_q || out_ready;
  assign accept  = valid_q && out_ready;

  // Next-state, slot and counter logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    trap_d  = trap_q;
    cnt_d   = cnt_q;
    pc_load = 1'b0;
    pc_incr = 1'b0;

    // Any accepted slot counts, including one leaving on a redirect edge.
    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid && is_misaligned(redirect_pc[1:0])) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          // Flush the slot even when decode has not taken it yet.
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (advance) begin
          valid_d = 1'b1;
          instr_d = imem_rd;
          opc_d   = pc;
          opc4_d  = pc_plus4;
          pc_incr = 1'b1;
        end
      end
      TRAP: begin
        valid_d = 1'b0;
        trap_d  = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      opc4_q  <= '0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      trap_q  <= trap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_ra     = pc;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign out_pc4     = opc4_q;
  assign trap        = trap_q;
  assign fetch_count = cnt_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a cycle-level reference model.
module tb_fetch_stage;

  localparam int unsigned AW    = 9;
  localparam int unsigned IW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned RPC   = 0;
  localparam int          SPACE = 1 << AW;
  localparam int          CMAX  = (1 << CW) - 1;
  localparam int          VW    = 1 + IW + AW + AW + 1 + CW + AW;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] imem_ra;
  logic [IW-1:0] imem_rd;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc4;
  logic          trap;
  logic [CW-1:0] fetch_count;

  logic [IW-1:0] rom [SPACE/4];

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .INS_ADDRESS (AW),
    .INS_W       (IW),
    .RESET_PC    (RPC),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_ra        (imem_ra),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .trap           (trap),
    .fetch_count    (fetch_count)
  );

  assign imem_rd = rom[imem_ra[AW-1:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      assert (imem_ra[1:0] == 2'b00)
        else $error("FAIL pc_align imem_ra=%h", imem_ra);
    end
  end

  // Reference model: stage described as booting / running / trapped,
  // one slot, a PC and a saturating accept count.
  bit          m_boot, m_trap, m_valid;
  logic [31:0] m_instr;
  int          m_pc, m_opc, m_opc4, m_cnt;

  task automatic model_reset();
    m_boot = 1; m_trap = 0; m_valid = 0; m_instr = '0;
    m_pc = RPC; m_opc = 0; m_opc4 = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = m_valid && out_ready;
    if (acc && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (m_trap) begin
      m_valid = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (redirect_valid && (int'(redirect_pc) % 4 != 0)) begin
      m_trap  = 1;
      m_valid = 0;
    end else if (redirect_valid) begin
      m_pc    = int'(redirect_pc);
      m_valid = 0;
    end else if (!m_valid || out_ready) begin
      m_instr = rom[m_pc / 4];
      m_opc   = m_pc;
      m_opc4  = (m_pc + 4) % SPACE;
      m_valid = 1;
      m_pc    = (m_pc + 4) % SPACE;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_instr, AW'(m_opc), AW'(m_opc4), m_trap, CW'(m_cnt), AW'(m_pc)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {out_valid, out_instr, out_pc, out_pc4, trap, fetch_count, imem_ra};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state got=%h want=%h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    out_ready = 1'b1; redirect_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL first_fetch_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        checks++;
        if ({out_valid, imem_ra} !== {1'b0, 9'h000}) begin
          errors++; $display("FAIL boot_hold got=%b/%h want=0/000", out_valid, imem_ra);
        end
      end
      if (k == 2) begin
        checks++;
        if ({out_valid, out_instr, out_pc, out_pc4} !== {1'b1, 32'h00007033, 9'h000, 9'h004}) begin
          errors++; $display("FAIL first_slot got=%b %h %h %h want=1 00007033 000 004",
                             out_valid, out_instr, out_pc, out_pc4);
        end
      end
      if (k == 3) begin
        checks++;
        if ({out_valid, out_instr, out_pc} !== {1'b1, 32'h00100093, 9'h004}) begin
          errors++; $display("FAIL second_slot got=%b %h %h want=1 00100093 004",
                             out_valid, out_instr, out_pc);
        end
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({out_valid, out_instr, out_pc, out_pc4, imem_ra, fetch_count} !==
          {1'b1, 32'h00200113, 9'h008, 9'h00C, 9'h00C, 4'd2}) begin
        errors++; $display("FAIL stall_hold k=%0d got=%b %h %h %h ra=%h cnt=%0d want=1 00200113 008 00c ra=00c cnt=2",
                           k, out_valid, out_instr, out_pc, out_pc4, imem_ra, fetch_count);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_instr, out_pc, fetch_count} !== {1'b1, rom[3], 9'h00C, 4'd3}) begin
      errors++; $display("FAIL stall_release got=%b %h %h cnt=%0d want=1 %h 00c cnt=3",
                         out_valid, out_instr, out_pc, fetch_count, rom[3]);
    end
  endtask

  task automatic test_redirect_stall();
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 9'h020;
    tick();
    checks++;
    if ({out_valid, imem_ra} !== {1'b0, 9'h020}) begin
      errors++; $display("FAIL redirect_flush got=%b ra=%h want=0 ra=020", out_valid, imem_ra);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_instr, out_pc, out_pc4} !== {1'b1, 32'h00208433, 9'h020, 9'h024}) begin
      errors++; $display("FAIL redirect_target got=%b %h %h %h want=1 00208433 020 024",
                         out_valid, out_instr, out_pc, out_pc4);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL redirect_model got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h1FC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_pc, out_pc4, imem_ra} !== {1'b1, 9'h1FC, 9'h000, 9'h000}) begin
      errors++; $display("FAIL wrap_last got=%b pc=%h pc4=%h ra=%h want=1 1fc 000 000",
                         out_valid, out_pc, out_pc4, imem_ra);
    end
    tick();
    checks++;
    if ({out_valid, out_instr, out_pc, out_pc4} !== {1'b1, 32'h00007033, 9'h000, 9'h004}) begin
      errors++; $display("FAIL wrap_first got=%b %h %h %h want=1 00007033 000 004",
                         out_valid, out_instr, out_pc, out_pc4);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrap_model got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = AW'($urandom_range(0, SPACE / 4 - 1) * 4);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; redirect_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL sat_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (fetch_count !== 4'hF) begin
      errors++; $display("FAIL saturate got=%0d want=15", fetch_count);
    end
  endtask

  task automatic test_trap();
    logic [AW-1:0] held_ra;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h022;
    held_ra = AW'(m_pc);
    tick();
    checks++;
    if ({trap, out_valid, imem_ra} !== {1'b1, 1'b0, held_ra}) begin
      errors++; $display("FAIL trap_enter got=%b %b ra=%h want=1 0 ra=%h", trap, out_valid, imem_ra, held_ra);
    end
    for (int k = 0; k < 6; k++) begin
      redirect_valid = ($urandom_range(0, 1) != 0);
      redirect_pc    = AW'($urandom_range(0, SPACE / 4 - 1) * 4);
      tick();
      checks++;
      if ({trap, out_valid, imem_ra} !== {1'b1, 1'b0, held_ra}) begin
        errors++; $display("FAIL trap_sticky k=%0d got=%b %b ra=%h want=1 0 ra=%h",
                           k, trap, out_valid, imem_ra, held_ra);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL trap_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1; redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL async_clear got=%h want=0", dut_vec());
    end
    // A redirect during BOOT must be ignored.
    redirect_valid = 1'b1; redirect_pc = 9'h040;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if ({out_valid, imem_ra, trap} !== {1'b0, 9'h000, 1'b0}) begin
      errors++; $display("FAIL boot_redirect got=%b ra=%h trap=%b want=0 ra=000 trap=0",
                         out_valid, imem_ra, trap);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_instr, out_pc, fetch_count} !== {1'b1, 32'h00007033, 9'h000, 4'd0}) begin
      errors++; $display("FAIL restart got=%b %h %h cnt=%0d want=1 00007033 000 cnt=0",
                         out_valid, out_instr, out_pc, fetch_count);
    end
    // Reset while a slot is stalled.
    out_ready = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL stall_reset got=%h want=0", dut_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL post_reset k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < SPACE / 4; i++) rom[i] = $urandom;
    rom[0] = 32'h00007033;
    rom[1] = 32'h00100093;
    rom[2] = 32'h00200113;
    rom[8] = 32'h00208433;

    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_random();
    test_saturation();
    test_trap();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_stage
